// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-style control unit and its datapath.
// Contents:
//   - FSM state codes (4-bit, also driven out on the debug state port)
//   - opcode constants (instruction[15:12])
//   - alu_Op codes, alu_src_b and pc_src mux encodings
//   - dispatch(): maps an opcode to the state that follows DECODE
package mips_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_FETCH    = 4'd1;
  localparam state_t ST_DECODE   = 4'd2;
  localparam state_t ST_EXEC_R   = 4'd3;
  localparam state_t ST_EXEC_I   = 4'd4;
  localparam state_t ST_R_WB     = 4'd5;
  localparam state_t ST_I_WB     = 4'd6;
  localparam state_t ST_MEM_ADDR = 4'd7;
  localparam state_t ST_MEM_RD   = 4'd8;
  localparam state_t ST_MEM_WB   = 4'd9;
  localparam state_t ST_MEM_WR   = 4'd10;
  localparam state_t ST_BRANCH   = 4'd11;
  localparam state_t ST_JUMP     = 4'd12;
  localparam state_t ST_HALT     = 4'd13;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_ANDI  = 4'b0010;
  localparam logic [3:0] OP_ORI   = 4'b0011;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_BNE   = 4'b0111;
  localparam logic [3:0] OP_J     = 4'b1000;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_ZEXT = 2'b10;
  localparam logic [1:0] SRCB_SEXT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State entered after DECODE. Unknown opcodes fall back to FETCH; no legal
  // opcode dispatches to FETCH, so that result doubles as the illegal flag.
  function automatic state_t dispatch(input logic [3:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:                nxt = ST_EXEC_R;
      OP_ADDI, OP_ANDI, OP_ORI: nxt = ST_EXEC_I;
      OP_LW, OP_SW:            nxt = ST_MEM_ADDR;
      OP_BEQ, OP_BNE:          nxt = ST_BRANCH;
      OP_J:                    nxt = ST_JUMP;
      OP_HALT:                 nxt = ST_HALT;
      default:                 nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_alu_op_decode.sv
// ALU operation select for the control FSM.
// Ports:
//   state_i  - current FSM state
//   op_i     - opcode (instruction[15:12])
//   funct_i  - R-type function field (instruction[2:0])
//   alu_op_o - ALU operation code
// FETCH/DECODE/MEM_ADDR add, EXEC_R passes funct straight through, EXEC_I
// picks by immediate opcode, BRANCH subtracts; everything else idles at 000.
module mc_alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [3:0] op_i,
  input  logic [2:0] funct_i,
  output logic [2:0] alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (state_i)
      ST_EXEC_R: alu_op_o = funct_i;
      ST_EXEC_I: begin
        case (op_i)
          OP_ANDI: alu_op_o = ALU_AND;
          OP_ORI:  alu_op_o = ALU_OR;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      ST_BRANCH: alu_op_o = ALU_SUB;
      default:   alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM (Moore) for a 16-bit MIPS-style datapath.
// Inputs : clk, rst_n (sync, active low), opcode, funct, zero_flag, mem_ready.
// Outputs: alu_Op, alu_src_a, alu_src_b, pc_write, ir_write, mem_read,
//          mem_write, reg_write, reg_dst, mem_to_reg, iord, pc_src,
//          illegal_op (DECODE-cycle pulse), halted (level),
//          dbg_state_o (current state code, for observation only).
// Outputs decode from the current state; mem_ready gates the FETCH strobes,
// zero_flag gates the branch pc_write, and opcode picks the EXEC_I/BRANCH
// variants and the illegal flag. Opcode/funct are only looked at from
// DECODE onward, when the IR holds the current instruction.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic [2:0]     funct,
  input  logic           zero_flag,
  input  logic           mem_ready,
  output logic [2:0]     alu_Op,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic           pc_write,
  output logic           ir_write,
  output logic           mem_read,
  output logic           mem_write,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           iord,
  output logic [1:0]     pc_src,
  output logic           illegal_op,
  output logic           halted,
  output logic [3:0]     dbg_state_o
);

  logic [3:0] state_q, state_d;
  logic [1:0] go_q;
  logic [3:0] op4;

  assign op4         = 4'(opcode);
  assign dbg_state_o = state_q;

  // go_q fills with ones after reset release; IDLE waits for go_q[1] so the
  // first FETCH lands two cycles after the first edge that sees rst_n high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      go_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      go_q    <= {go_q[0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (go_q[1]) state_d = ST_FETCH;
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE:   state_d = dispatch(op4);
      ST_EXEC_R:   state_d = ST_R_WB;
      ST_EXEC_I:   state_d = ST_I_WB;
      ST_R_WB:     state_d = ST_FETCH;
      ST_I_WB:     state_d = ST_FETCH;
      ST_MEM_ADDR: state_d = (op4 == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_IDLE;
    endcase
  end

  mc_alu_op_decode u_alu_op_decode (
    .state_i  (state_q),
    .op_i     (op4),
    .funct_i  (funct),
    .alu_op_o (alu_Op)
  );

  always_comb begin
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    iord       = 1'b0;
    pc_src     = PCSRC_ALU;
    illegal_op = 1'b0;
    halted     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        // IR and PC latch only in the cycle memory returns the word.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b  = SRCB_SEXT;
        illegal_op = (dispatch(op4) == ST_FETCH);
      end
      ST_EXEC_R: alu_src_a = 1'b1;
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = (op4 == OP_ADDI) ? SRCB_SEXT : SRCB_ZEXT;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_I_WB: reg_write = 1'b1;
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
      end
      ST_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = (op4 == OP_BNE) ? ~zero_flag : zero_flag;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm. Each driven cycle pushes the hand-written
// expected control word (state + every output) into exp_q; a monitor on the
// falling edge pops and compares whenever an expectation is pending.
module tb_mc_control_fsm;
  import mips_ctrl_pkg::*;

  localparam int W = 22;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'b0;
  logic [2:0] funct = 3'b0;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] alu_Op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic       reg_dst, mem_to_reg, iord;
  logic [1:0] pc_src;
  logic       illegal_op, halted;
  logic [3:0] dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  mc_control_fsm #(.OPW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero_flag  (zero_flag),
    .mem_ready  (mem_ready),
    .alu_Op     (alu_Op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .iord       (iord),
    .pc_src     (pc_src),
    .illegal_op (illegal_op),
    .halted     (halted),
    .dbg_state_o(dbg_state)
  );

  logic [W-1:0] act_w;
  assign act_w = {dbg_state, alu_Op, alu_src_a, alu_src_b,
                  pc_write, ir_write, mem_read, mem_write,
                  reg_write, reg_dst, mem_to_reg, iord,
                  pc_src, illegal_op, halted};

  // strb = {pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, iord}
  function automatic logic [W-1:0] w(input logic [3:0] st, input logic [2:0] aop,
                                     input logic sa, input logic [1:0] sb,
                                     input logic [7:0] strb, input logic [1:0] ps,
                                     input logic ill, input logic hlt);
    return {st, aop, sa, sb, strb, ps, ill, hlt};
  endfunction

  logic [W-1:0] w_idle, w_fetch_stall, w_fetch_go, w_dec, w_dec_ill;
  logic [W-1:0] w_r_wb, w_i_wb, w_mem_addr, w_mem_rd, w_mem_wb, w_mem_wr;
  logic [W-1:0] w_br_taken, w_br_not, w_jump, w_halt;
  logic [W-1:0] w_addi, w_andi, w_ori;

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           failures = 0;

  // driver
  task automatic cyc(input logic rst, input logic [3:0] opc, input logic [2:0] fn,
                     input logic zf, input logic mr, input logic [W-1:0] e,
                     input string tag);
    @(posedge clk);
    #1;
    rst_n     = rst;
    opcode    = opc;
    funct     = fn;
    zero_flag = zf;
    mem_ready = mr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // FETCH (one stall then ready) followed by DECODE
  task automatic fetch_dec(input logic [3:0] opc, input logic [2:0] fn,
                           input logic [W-1:0] dec_w);
    cyc(1'b1, opc, fn, 1'b0, 1'b0, w_fetch_stall, "fetch_stall");
    cyc(1'b1, opc, fn, 1'b0, 1'b1, w_fetch_go, "fetch");
    cyc(1'b1, opc, fn, 1'b0, 1'b0, dec_w, "decode");
  endtask

  // First cycle sees rst_n sampled low (driven high here), then two IDLE
  // cycles before the FSM reaches FETCH.
  task automatic release_seq();
    cyc(1'b1, 4'b0, 3'b0, 1'b0, 1'b1, w_idle, "rst_idle");
    cyc(1'b1, 4'b0, 3'b0, 1'b0, 1'b1, w_idle, "rel_idle1");
    cyc(1'b1, 4'b0, 3'b0, 1'b0, 1'b1, w_idle, "rel_idle2");
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    string        t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (act_w !== e) begin
          failures++;
          $display("FAIL %s: got %06h expected %06h (t=%0t)", t, act_w, e, $time);
        end
        checks++;
        if (mem_read === 1'b1 && mem_write === 1'b1) begin
          failures++;
          $display("FAIL mem_excl %s: got mem_read=1 mem_write=1 expected not both", t);
        end
      end
    end
  end

  initial begin
    w_idle        = w(ST_IDLE,     3'b000, 1'b0, 2'b00, 8'b0000_0000, 2'b00, 1'b0, 1'b0);
    w_fetch_stall = w(ST_FETCH,    3'b000, 1'b0, 2'b01, 8'b0010_0000, 2'b00, 1'b0, 1'b0);
    w_fetch_go    = w(ST_FETCH,    3'b000, 1'b0, 2'b01, 8'b1110_0000, 2'b00, 1'b0, 1'b0);
    w_dec         = w(ST_DECODE,   3'b000, 1'b0, 2'b11, 8'b0000_0000, 2'b00, 1'b0, 1'b0);
    w_dec_ill     = w(ST_DECODE,   3'b000, 1'b0, 2'b11, 8'b0000_0000, 2'b00, 1'b1, 1'b0);
    w_r_wb        = w(ST_R_WB,     3'b000, 1'b0, 2'b00, 8'b0000_1100, 2'b00, 1'b0, 1'b0);
    w_i_wb        = w(ST_I_WB,     3'b000, 1'b0, 2'b00, 8'b0000_1000, 2'b00, 1'b0, 1'b0);
    w_addi        = w(ST_EXEC_I,   3'b000, 1'b1, 2'b11, 8'b0000_0000, 2'b00, 1'b0, 1'b0);
    w_andi        = w(ST_EXEC_I,   3'b010, 1'b1, 2'b10, 8'b0000_0000, 2'b00, 1'b0, 1'b0);
    w_ori         = w(ST_EXEC_I,   3'b011, 1'b1, 2'b10, 8'b0000_0000, 2'b00, 1'b0, 1'b0);
    w_mem_addr    = w(ST_MEM_ADDR, 3'b000, 1'b1, 2'b11, 8'b0000_0000, 2'b00, 1'b0, 1'b0);
    w_mem_rd      = w(ST_MEM_RD,   3'b000, 1'b0, 2'b00, 8'b0010_0001, 2'b00, 1'b0, 1'b0);
    w_mem_wb      = w(ST_MEM_WB,   3'b000, 1'b0, 2'b00, 8'b0000_1010, 2'b00, 1'b0, 1'b0);
    w_mem_wr      = w(ST_MEM_WR,   3'b000, 1'b0, 2'b00, 8'b0001_0001, 2'b00, 1'b0, 1'b0);
    w_br_taken    = w(ST_BRANCH,   3'b001, 1'b1, 2'b00, 8'b1000_0000, 2'b01, 1'b0, 1'b0);
    w_br_not      = w(ST_BRANCH,   3'b001, 1'b1, 2'b00, 8'b0000_0000, 2'b01, 1'b0, 1'b0);
    w_jump        = w(ST_JUMP,     3'b000, 1'b0, 2'b00, 8'b1000_0000, 2'b10, 1'b0, 1'b0);
    w_halt        = w(ST_HALT,     3'b000, 1'b0, 2'b00, 8'b0000_0000, 2'b00, 1'b0, 1'b1);

    // reset, release, R-type XOR
    cyc(1'b0, 4'b0, 3'b101, 1'b0, 1'b1, w_idle, "reset_idle0");
    cyc(1'b0, 4'b0, 3'b101, 1'b0, 1'b1, w_idle, "reset_idle1");
    release_seq();
    cyc(1'b1, OP_RTYPE, 3'b101, 1'b0, 1'b1, w_fetch_go, "first_fetch");
    cyc(1'b1, OP_RTYPE, 3'b101, 1'b0, 1'b1, w_dec, "r_decode");
    cyc(1'b1, OP_RTYPE, 3'b101, 1'b0, 1'b1,
        w(ST_EXEC_R, 3'b101, 1'b1, 2'b00, 8'b0, 2'b00, 1'b0, 1'b0), "exec_r_xor");
    cyc(1'b1, OP_RTYPE, 3'b101, 1'b0, 1'b1, w_r_wb, "r_wb");

    // LW with three wait cycles in MEM_RD
    fetch_dec(OP_LW, 3'b000, w_dec);
    cyc(1'b1, OP_LW, 3'b000, 1'b0, 1'b0, w_mem_addr, "lw_addr");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, OP_LW, 3'b000, 1'b0, 1'b0, w_mem_rd, "lw_rd_wait");
    cyc(1'b1, OP_LW, 3'b000, 1'b0, 1'b1, w_mem_rd, "lw_rd_done");
    cyc(1'b1, OP_LW, 3'b000, 1'b0, 1'b0, w_mem_wb, "lw_wb");

    // branches, both polarities of zero_flag
    fetch_dec(OP_BEQ, 3'b000, w_dec);
    cyc(1'b1, OP_BEQ, 3'b000, 1'b1, 1'b0, w_br_taken, "beq_z1");
    fetch_dec(OP_BNE, 3'b000, w_dec);
    cyc(1'b1, OP_BNE, 3'b000, 1'b1, 1'b0, w_br_not, "bne_z1");
    fetch_dec(OP_BNE, 3'b000, w_dec);
    cyc(1'b1, OP_BNE, 3'b000, 1'b0, 1'b0, w_br_taken, "bne_z0");
    fetch_dec(OP_BEQ, 3'b000, w_dec);
    cyc(1'b1, OP_BEQ, 3'b000, 1'b0, 1'b0, w_br_not, "beq_z0");

    // immediates
    fetch_dec(OP_ADDI, 3'b111, w_dec);
    cyc(1'b1, OP_ADDI, 3'b111, 1'b0, 1'b0, w_addi, "exec_addi");
    cyc(1'b1, OP_ADDI, 3'b111, 1'b0, 1'b0, w_i_wb, "addi_wb");
    fetch_dec(OP_ANDI, 3'b000, w_dec);
    cyc(1'b1, OP_ANDI, 3'b000, 1'b0, 1'b0, w_andi, "exec_andi");
    cyc(1'b1, OP_ANDI, 3'b000, 1'b0, 1'b0, w_i_wb, "andi_wb");
    fetch_dec(OP_ORI, 3'b000, w_dec);
    cyc(1'b1, OP_ORI, 3'b000, 1'b0, 1'b0, w_ori, "exec_ori");
    cyc(1'b1, OP_ORI, 3'b000, 1'b0, 1'b0, w_i_wb, "ori_wb");

    // jump, then illegal opcode (next FETCH proves the one-cycle pulse)
    fetch_dec(OP_J, 3'b000, w_dec);
    cyc(1'b1, OP_J, 3'b000, 1'b0, 1'b0, w_jump, "jump");
    fetch_dec(4'b1010, 3'b000, w_dec_ill);

    // SW stalled in MEM_WR, reset lands mid-stall
    fetch_dec(OP_SW, 3'b000, w_dec);
    cyc(1'b1, OP_SW, 3'b000, 1'b0, 1'b0, w_mem_addr, "sw_addr");
    cyc(1'b1, OP_SW, 3'b000, 1'b0, 1'b0, w_mem_wr, "sw_wait");
    cyc(1'b1, OP_SW, 3'b000, 1'b0, 1'b0, w_mem_wr, "sw_wait");
    cyc(1'b0, OP_SW, 3'b000, 1'b0, 1'b0, w_mem_wr, "sw_rst_assert");
    release_seq();

    // R-type SLL after the SW reset
    fetch_dec(OP_RTYPE, 3'b110, w_dec);
    cyc(1'b1, OP_RTYPE, 3'b110, 1'b0, 1'b0,
        w(ST_EXEC_R, 3'b110, 1'b1, 2'b00, 8'b0, 2'b00, 1'b0, 1'b0), "exec_r_sll");
    cyc(1'b1, OP_RTYPE, 3'b110, 1'b0, 1'b0, w_r_wb, "sll_wb");

    // HALT holds for 20 cycles whatever the inputs do, then reset clears it
    fetch_dec(OP_HALT, 3'b000, w_dec);
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 4'(i), 3'(i), i[0], i[1], w_halt, "halt_hold");
    cyc(1'b0, 4'b0, 3'b0, 1'b0, 1'b1, w_halt, "halt_rst_assert");
    release_seq();
    fetch_dec(OP_J, 3'b000, w_dec);
    cyc(1'b1, OP_J, 3'b000, 1'b0, 1'b0, w_jump, "jump_after_halt");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
